// File: rtl/sme_mem_pkg.sv
// Shared widths, arbitration-mode constants and helpers for the SME memory arbiter.
package sme_mem_pkg;

    localparam int DEF_NUM_PORTS   = 4;
    localparam int DEF_ADDR_WIDTH  = 10;
    localparam int DEF_WDATA_WIDTH = 9;
    localparam int DEF_RDATA_WIDTH = 18;
    localparam int DEF_RD_LATENCY  = 1;
    localparam int DEF_MAX_BURST   = 8;

    // Arbitration policy selectors for the ARB_MODE parameter.
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Grant lock state: open arbitration, or one port holding the grant.
    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Width of a port index; never below one bit.
    function automatic int port_id_width(input int num_ports);
        return (num_ports <= 2) ? 1 : $clog2(num_ports);
    endfunction

endpackage

// File: rtl/sme_rr_arbiter.sv
// Single-grant arbiter: round-robin or fixed priority, with lock and burst limit.
module sme_rr_arbiter
    import sme_mem_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int ARB_MODE  = ARB_RR,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int PW        = port_id_width(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req_valid,
    input  logic [NUM_PORTS-1:0] req_lock,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 grant_vld,
    output logic [PW-1:0]        grant_id
);

    localparam logic [7:0]    MAX_BURST_C = 8'(MAX_BURST);
    localparam logic [PW-1:0] LAST_PORT   = PW'(NUM_PORTS - 1);

    arb_state_e    state_q, state_d;
    logic [PW-1:0] last_q, last_d;
    logic [PW-1:0] lock_port_q, lock_port_d;
    logic [7:0]    burst_q, burst_d;
    logic [7:0]    beats;

    logic          sel_vld;
    logic [PW-1:0] sel_id;
    logic [PW-1:0] cand;

    // Pick the winner: a locked port keeps the grant while it stays valid,
    // otherwise fixed priority or a round-robin search after the last grant.
    always_comb begin
        sel_vld = 1'b0;
        sel_id  = '0;
        cand    = '0;
        if (state_q == ARB_LOCKED && req_valid[lock_port_q]) begin
            sel_vld = 1'b1;
            sel_id  = lock_port_q;
        end else if (ARB_MODE == ARB_FIXED) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                cand = PW'(i);
                if (!sel_vld && req_valid[cand]) begin
                    sel_vld = 1'b1;
                    sel_id  = cand;
                end
            end
        end else begin
            for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
                cand = PW'((i + int'(last_q)) % NUM_PORTS);
                if (!sel_vld && req_valid[cand]) begin
                    sel_vld = 1'b1;
                    sel_id  = cand;
                end
            end
        end
    end

    // Present the grant; held at zero while reset is asserted.
    always_comb begin
        grant     = '0;
        grant_vld = sel_vld & rst_n;
        grant_id  = sel_id;
        if (grant_vld) begin
            grant[sel_id] = 1'b1;
        end
    end

    // Track last grant, lock ownership and consecutive locked beats.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        lock_port_d = lock_port_q;
        burst_d     = burst_q;
        beats       = 8'd1;
        if (grant_vld) begin
            last_d = sel_id;
            if (state_q == ARB_LOCKED && lock_port_q == sel_id) begin
                beats = burst_q + 8'd1;
            end
            // Reaching the burst limit drops the lock; since last_d is this
            // port, round-robin then treats it as lowest priority.
            if (req_lock[sel_id] && beats < MAX_BURST_C) begin
                state_d     = ARB_LOCKED;
                lock_port_d = sel_id;
                burst_d     = beats;
            end else begin
                state_d = ARB_OPEN;
                burst_d = '0;
            end
        end else begin
            state_d = ARB_OPEN;
            burst_d = '0;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB_OPEN;
            last_q      <= LAST_PORT;
            lock_port_q <= '0;
            burst_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            lock_port_q <= lock_port_d;
            burst_q     <= burst_d;
        end
    end

endmodule

// File: rtl/sme_memory_arbiter.sv
// Shares one memory block among NUM_PORTS requesters: grant, registered
// memory command and a port-tagged read-response pipeline.
module sme_memory_arbiter
    import sme_mem_pkg::*;
#(
    parameter int NUM_PORTS   = DEF_NUM_PORTS,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WDATA_WIDTH = DEF_WDATA_WIDTH,
    parameter int RDATA_WIDTH = DEF_RDATA_WIDTH,
    parameter int RD_LATENCY  = DEF_RD_LATENCY,
    parameter int ARB_MODE    = ARB_RR,
    parameter int MAX_BURST   = DEF_MAX_BURST
) (
    input  logic                             ClockIn,
    input  logic                             ResetIn_n,
    input  logic [NUM_PORTS-1:0]             ReqValid,
    input  logic [NUM_PORTS-1:0]             ReqWrite,
    input  logic [NUM_PORTS-1:0]             ReqLock,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  ReqAddr,
    input  logic [NUM_PORTS*WDATA_WIDTH-1:0] ReqWData,
    output logic [NUM_PORTS-1:0]             ReqReady,
    output logic [NUM_PORTS-1:0]             RspValid,
    output logic [RDATA_WIDTH-1:0]           RspData,
    output logic [ADDR_WIDTH-1:0]            MemReadAddr,
    output logic                             MemReadEnable,
    output logic [ADDR_WIDTH-1:0]            MemWriteAddr,
    output logic [WDATA_WIDTH-1:0]           MemWriteData,
    output logic                             MemWriteEnable,
    input  logic [RDATA_WIDTH-1:0]           MemReadData
);

    localparam int PW = port_id_width(NUM_PORTS);

    logic                   grant_vld;
    logic [PW-1:0]          grant_id;

    logic [ADDR_WIDTH-1:0]  port_addr  [NUM_PORTS];
    logic [WDATA_WIDTH-1:0] port_wdata [NUM_PORTS];

    logic                   mem_re_q, mem_re_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [WDATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [PW-1:0]          rd_port_q, rd_port_d;

    logic [RD_LATENCY-1:0]         rsp_vld_q, rsp_vld_d;
    logic [RD_LATENCY-1:0][PW-1:0] rsp_port_q, rsp_port_d;

    sme_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .ARB_MODE  (ARB_MODE),
        .MAX_BURST (MAX_BURST),
        .PW        (PW)
    ) u_arbiter (
        .clk       (ClockIn),
        .rst_n     (ResetIn_n),
        .req_valid (ReqValid),
        .req_lock  (ReqLock),
        .grant     (ReqReady),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign port_addr[p]  = ReqAddr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign port_wdata[p] = ReqWData[p*WDATA_WIDTH +: WDATA_WIDTH];
    end

    // Build the next memory command from the accepted beat; address and
    // data hold their previous values when no command is issued.
    always_comb begin
        mem_re_d  = 1'b0;
        mem_we_d  = 1'b0;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_port_d = rd_port_q;
        if (grant_vld) begin
            if (ReqWrite[grant_id]) begin
                mem_we_d  = 1'b1;
                wr_addr_d = port_addr[grant_id];
                wr_data_d = port_wdata[grant_id];
            end else begin
                mem_re_d  = 1'b1;
                rd_addr_d = port_addr[grant_id];
                rd_port_d = grant_id;
            end
        end
    end

    // The response pipeline starts at the issued read command, so its last
    // stage lines up with MemReadData RD_LATENCY cycles later.
    assign rsp_vld_d[0]  = mem_re_q;
    assign rsp_port_d[0] = rd_port_q;
    for (genvar s = 1; s < RD_LATENCY; s++) begin : g_rsp_shift
        assign rsp_vld_d[s]  = rsp_vld_q[s-1];
        assign rsp_port_d[s] = rsp_port_q[s-1];
    end

    // Command and response registers; reset discards any read in flight.
    always_ff @(posedge ClockIn) begin
        if (!ResetIn_n) begin
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_port_q  <= '0;
            rsp_vld_q  <= '0;
            rsp_port_q <= '0;
        end else begin
            mem_re_q   <= mem_re_d;
            mem_we_q   <= mem_we_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_port_q  <= rd_port_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_port_q <= rsp_port_d;
        end
    end

    // Decode the tagged response strobe and qualify the shared data.
    always_comb begin
        RspValid = '0;
        RspData  = '0;
        if (rsp_vld_q[RD_LATENCY-1]) begin
            RspValid[rsp_port_q[RD_LATENCY-1]] = 1'b1;
            RspData = MemReadData;
        end
    end

    assign MemReadEnable  = mem_re_q;
    assign MemReadAddr    = rd_addr_q;
    assign MemWriteEnable = mem_we_q;
    assign MemWriteAddr   = wr_addr_q;
    assign MemWriteData   = wr_data_q;

endmodule

// File: tb/tb_sme_memory_arbiter.sv
// Bench for sme_memory_arbiter: three configurations share one stimulus
// stream, each checked every cycle against a transaction-level model.
module tb_sme_memory_arbiter;

    localparam int NP   = 4;
    localparam int AW   = 10;
    localparam int WW   = 9;
    localparam int RW   = 18;
    localparam int NCFG = 3;

    typedef struct {
        int              due;
        int              port;
        logic [RW-1:0]   data;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     req_valid;
    logic [NP-1:0]     req_write;
    logic [NP-1:0]     req_lock;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*WW-1:0]  req_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Power-up content of the memory, used by the memory model and the reference.
    function automatic logic [RW-1:0] mem_init(input int a);
        return RW'(a * 37 + 11);
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int ARB = (g == 1) ? 1 : 0;
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 3);
        localparam int MB  = (g == 2) ? 3 : 8;

        logic [NP-1:0] ready;
        logic [NP-1:0] rsp_valid;
        logic [RW-1:0] rsp_data;
        logic [RW-1:0] mrdata;
        logic [AW-1:0] mraddr, mwaddr;
        logic [WW-1:0] mwdata;
        logic          mre, mwe;

        sme_memory_arbiter #(
            .NUM_PORTS   (NP),
            .ADDR_WIDTH  (AW),
            .WDATA_WIDTH (WW),
            .RDATA_WIDTH (RW),
            .RD_LATENCY  (LAT),
            .ARB_MODE    (ARB),
            .MAX_BURST   (MB)
        ) u_dut (
            .ClockIn        (clk),
            .ResetIn_n      (rst_n),
            .ReqValid       (req_valid),
            .ReqWrite       (req_write),
            .ReqLock        (req_lock),
            .ReqAddr        (req_addr),
            .ReqWData       (req_wdata),
            .ReqReady       (ready),
            .RspValid       (rsp_valid),
            .RspData        (rsp_data),
            .MemReadAddr    (mraddr),
            .MemReadEnable  (mre),
            .MemWriteAddr   (mwaddr),
            .MemWriteData   (mwdata),
            .MemWriteEnable (mwe),
            .MemReadData    (mrdata)
        );

        // Memory block with LAT cycles from read enable to data.
        logic [RW-1:0] mem     [1<<AW];
        bit            seen    [1<<AW];
        logic [RW-1:0] rd_pipe [LAT];
        always @(posedge clk) begin
            if (mwe) begin
                mem[mwaddr]  <= RW'(mwdata);
                seen[mwaddr] <= 1'b1;
            end
            rd_pipe[0] <= mre ? (seen[mraddr] ? mem[mraddr] : mem_init(int'(mraddr))) : '0;
            for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
        assign mrdata = rd_pipe[LAT-1];

        // Reference: arbitration rules, shadow memory and expected responses.
        logic [RW-1:0] ref_mem  [1<<AW];
        bit            ref_seen [1<<AW];
        rsp_t          rspq[$];
        int            last      = NP - 1;
        int            lock_port = -1;
        int            cnt       = 0;
        int            cyc       = 0;
        bit            armed     = 1'b0;
        logic          e_re = 1'b0, e_we = 1'b0;
        logic [AW-1:0] e_raddr = '0, e_waddr = '0;
        logic [WW-1:0] e_wdata = '0;

        always @(negedge clk) begin : model
            int            exp_g;
            int            p;
            int            nb;
            logic [NP-1:0] exp_rv;
            logic [RW-1:0] exp_rd;
            logic [AW-1:0] a;

            exp_g = -1;
            if (rst_n) begin
                if (lock_port >= 0 && req_valid[lock_port]) begin
                    exp_g = lock_port;
                end else if (ARB == 1) begin
                    for (int i = 0; i < NP; i++)
                        if (exp_g < 0 && req_valid[i]) exp_g = i;
                end else begin
                    for (int i = 1; i <= NP; i++) begin
                        p = (last + i) % NP;
                        if (exp_g < 0 && req_valid[p]) exp_g = p;
                    end
                end
            end
            check_eq($sformatf("cfg%0d ready", g), 64'(ready),
                     64'((exp_g < 0) ? 0 : (1 << exp_g)));

            if (armed) begin
                exp_rv = '0;
                exp_rd = '0;
                while (rspq.size() > 0 && rspq[0].due <= cyc) begin
                    if (rspq[0].due == cyc) begin
                        exp_rv[rspq[0].port] = 1'b1;
                        exp_rd = rspq[0].data;
                    end
                    void'(rspq.pop_front());
                end
                check_eq($sformatf("cfg%0d rsp_valid", g), 64'(rsp_valid), 64'(exp_rv));
                if (exp_rv != '0)
                    check_eq($sformatf("cfg%0d rsp_data", g), 64'(rsp_data), 64'(exp_rd));
                check_eq($sformatf("cfg%0d mem_re", g), 64'(mre), 64'(e_re));
                check_eq($sformatf("cfg%0d mem_we", g), 64'(mwe), 64'(e_we));
                check_eq($sformatf("cfg%0d mem_raddr", g), 64'(mraddr), 64'(e_raddr));
                check_eq($sformatf("cfg%0d mem_waddr", g), 64'(mwaddr), 64'(e_waddr));
                check_eq($sformatf("cfg%0d mem_wdata", g), 64'(mwdata), 64'(e_wdata));
            end

            // Effect of the coming rising edge.
            if (!rst_n) begin
                armed     = 1'b1;
                last      = NP - 1;
                lock_port = -1;
                cnt       = 0;
                rspq.delete();
                e_re = 1'b0; e_we = 1'b0;
                e_raddr = '0; e_waddr = '0; e_wdata = '0;
            end else begin
                e_re = 1'b0;
                e_we = 1'b0;
                if (exp_g >= 0) begin
                    nb   = (lock_port == exp_g) ? cnt + 1 : 1;
                    last = exp_g;
                    if (req_lock[exp_g] && nb < MB) begin
                        lock_port = exp_g;
                        cnt       = nb;
                    end else begin
                        lock_port = -1;
                        cnt       = 0;
                    end
                    a = req_addr[exp_g*AW +: AW];
                    if (req_write[exp_g]) begin
                        e_we          = 1'b1;
                        e_waddr       = a;
                        e_wdata       = req_wdata[exp_g*WW +: WW];
                        ref_mem[a]    = RW'(e_wdata);
                        ref_seen[a]   = 1'b1;
                    end else begin
                        e_re    = 1'b1;
                        e_raddr = a;
                        rspq.push_back('{cyc + 1 + LAT, exp_g,
                                         ref_seen[a] ? ref_mem[a] : mem_init(int'(a))});
                    end
                end else begin
                    lock_port = -1;
                    cnt       = 0;
                end
            end
            cyc++;
        end
    end

    task automatic drive(input logic [NP-1:0] v, input logic [NP-1:0] w, input logic [NP-1:0] l);
        req_valid = v;
        req_write = w;
        req_lock  = l;
        for (int p = 0; p < NP; p++) begin
            req_addr[p*AW +: AW]  = AW'($urandom);
            req_wdata[p*WW +: WW] = WW'($urandom);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int            exp36 [5];
        logic [NP-1:0] tags[$];
        int            first_c, last_c, k;
        bit            found;

        exp36 = '{2, 2, 2, 3, 1};
        rst_n = 1'b0;
        drive('0, '0, '0);
        repeat (3) step();
        rst_n = 1'b1;

        // All four ports reading: round-robin order and response order.
        drive(4'hF, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("rr_grant_seq", 64'(g_cfg[0].ready), 64'(1 << (i % 4)));
            if (i >= 2) check_eq("rr_rsp_seq", 64'(g_cfg[0].rsp_valid), 64'(1 << (i - 2)));
            step();
        end
        drive('0, '0, '0);
        repeat (6) step();

        // Locked burst on port 2 limited to three beats.
        drive(4'b0100, 4'h0, 4'b0100);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("burst_grant_seq", 64'(g_cfg[2].ready), 64'(1 << exp36[i]));
            step();
            drive(4'b1110, 4'h0, 4'b0100);
        end
        drive('0, '0, '0);
        repeat (4) step();

        // Fixed priority: port 1 always beats port 3.
        drive(4'b1010, 4'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("fixed_prio_grant", 64'(g_cfg[1].ready), 64'(4'b0010));
            step();
        end
        drive('0, '0, '0);
        repeat (4) step();

        // Write then read of the same address.
        drive(4'b0001, 4'b0001, 4'h0);
        req_addr[0 +: AW]  = 10'h3A;
        req_wdata[0 +: WW] = 9'h155;
        @(negedge clk);
        check_eq("wr_grant", 64'(g_cfg[0].ready), 64'(4'b0001));
        step();
        drive(4'b0010, 4'h0, 4'h0);
        req_addr[AW +: AW] = 10'h3A;
        @(negedge clk);
        check_eq("wr_cmd_we", 64'(g_cfg[0].mwe), 64'(1));
        check_eq("wr_cmd_addr", 64'(g_cfg[0].mwaddr), 64'(10'h3A));
        check_eq("wr_cmd_data", 64'(g_cfg[0].mwdata), 64'(9'h155));
        step();
        drive('0, '0, '0);
        found = 1'b0;
        for (k = 0; k < 6 && !found; k++) begin
            @(negedge clk);
            if (g_cfg[0].rsp_valid[1]) begin
                found = 1'b1;
                check_eq("rd_after_wr_data", 64'(g_cfg[0].rsp_data), 64'(18'h155));
            end
            step();
        end
        check_eq("rd_after_wr_seen", 64'(found), 64'(1));
        repeat (6) step();

        // Six back-to-back reads alternating ports 0 and 2, latency 3.
        first_c = -1;
        last_c  = -1;
        for (int i = 0; i < 14; i++) begin
            if (i < 6) drive((i % 2) ? 4'b0100 : 4'b0001, 4'h0, 4'h0);
            else       drive('0, '0, '0);
            @(negedge clk);
            if (g_cfg[2].rsp_valid != '0) begin
                tags.push_back(g_cfg[2].rsp_valid);
                if (first_c < 0) first_c = i;
                last_c = i;
            end
            step();
        end
        check_eq("b2b_rsp_count", 64'(tags.size()), 64'(6));
        check_eq("b2b_rsp_span", 64'(last_c - first_c), 64'(5));
        foreach (tags[i])
            check_eq("b2b_rsp_tag", 64'(tags[i]), 64'((i % 2) ? 4'b0100 : 4'b0001));

        // Reset with reads in flight.
        drive(4'b0110, 4'h0, 4'h0);
        repeat (2) step();
        rst_n = 1'b0;
        drive(4'hF, 4'hF, 4'h0);
        @(negedge clk);
        check_eq("ready_in_reset", 64'(g_cfg[0].ready), 64'(0));
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_reset_grant_rr", 64'(g_cfg[0].ready), 64'(4'b0001));
        check_eq("post_reset_grant_lat3", 64'(g_cfg[2].ready), 64'(4'b0001));
        step();
        drive('0, '0, '0);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            for (int c = 0; c < NCFG; c++) ;
            if (g_cfg[0].rsp_valid != '0 || g_cfg[1].rsp_valid != '0 || g_cfg[2].rsp_valid != '0)
                k++;
            step();
        end
        check_eq("no_rsp_after_reset", 64'(k), 64'(0));

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 249) != 0);
            req_valid = NP'($urandom) | NP'($urandom);
            req_write = NP'($urandom);
            req_lock  = ((c % 400) < 200) ? NP'($urandom) : '1;
            for (int p = 0; p < NP; p++) begin
                req_addr[p*AW +: AW]  = AW'($urandom_range(0, 15));
                req_wdata[p*WW +: WW] = WW'($urandom);
            end
            step();
        end
        rst_n = 1'b1;
        drive('0, '0, '0);
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sme_memory_arbiter.md
SME_MEMORY_ARBITER -- requirements
Module: sme_memory_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of requesters sharing one memory block (legal 2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, memory address width.
REQ-003 SHALL have parameter WDATA_WIDTH, default 9, write data width.
REQ-004 SHALL have parameter RDATA_WIDTH, default 18, read data width.
REQ-005 SHALL have parameter RD_LATENCY, default 1, memory cycles from MemReadEnable to valid MemReadData (legal 1..4).
REQ-006 SHALL have parameter ARB_MODE, default 0, arbitration policy (0 round-robin, 1 fixed priority, lowest index wins).
REQ-007 SHALL have parameter MAX_BURST, default 8, maximum consecutive locked grants to one port (legal 1..255).
REQ-008 SHALL have ports: ClockIn  in  1  sole clock, all logic on rising edge.
REQ-009 ResetIn_n  in  1  reset, synchronous, active-low.
REQ-010 ReqValid  in  NUM_PORTS  per-port request valid.
REQ-011 ReqWrite  in  NUM_PORTS  per-port 1 = write, 0 = read.
REQ-012 ReqLock  in  NUM_PORTS  per-port request to keep grant for next beat.
REQ-013 ReqAddr  in  NUM_PORTS*ADDR_WIDTH  packed addresses, port p at slice p.
REQ-014 ReqWData  in  NUM_PORTS*WDATA_WIDTH  packed write data.
REQ-015 ReqReady  out  NUM_PORTS  one-hot-or-zero grant; beat accepted when ReqValid[p] & ReqReady[p].
REQ-016 RspValid  out  NUM_PORTS  one-hot-or-zero read-response strobe.
REQ-017 RspData  out  RDATA_WIDTH  read data, shared by all ports, qualified by RspValid.
REQ-018 MemReadAddr  out  ADDR_WIDTH / MemReadEnable  out  1 / MemWriteAddr  out  ADDR_WIDTH / MemWriteData  out  WDATA_WIDTH / MemWriteEnable  out  1  registered memory command.
REQ-019 MemReadData  in  RDATA_WIDTH  memory read data.

Function
REQ-020 ReqReady SHALL be combinational from ReqValid and arbiter state; at most one bit set; zero when no ReqValid.
REQ-021 ARB_MODE 0: search SHALL start at (LastGrant+1) mod NUM_PORTS; LastGrant updates on every accepted beat.
REQ-022 ARB_MODE 1: lowest-index valid port SHALL win; lock rules still apply.
REQ-023 Lock: if accepted beat has ReqLock=1, same port SHALL win next cycle provided its ReqValid=1; lock clears on accepted beat with ReqLock=0, on ReqValid=0 of locked port, or when burst count reaches MAX_BURST.
REQ-024 Burst counter SHALL count consecutive accepted beats of locked port; on reaching MAX_BURST lock is forced off and that port is lowest priority in round-robin for the next decision.
REQ-025 Accepted beat at cycle N SHALL drive Mem* command at cycle N+1 for exactly one cycle; MemReadEnable and MemWriteEnable never both 1.
REQ-026 Mem address/data outputs SHALL hold last value when enables are 0.
REQ-027 Read accepted at N SHALL produce RspValid[p]=1 with RspData=MemReadData at cycle N+1+RD_LATENCY, single cycle; writes produce no response.
REQ-028 Port ID for in-flight reads SHALL be carried in a RD_LATENCY-deep pipeline; back-to-back reads every cycle SHALL be sustained with no bubbles.
REQ-029 Throughput: one beat per cycle, any mix of ports and read/write.

Reset
REQ-030 While ResetIn_n=0 at a rising edge: ReqReady, RspValid, MemReadEnable, MemWriteEnable, addresses, data, RspData SHALL be 0; lock and burst counter cleared; LastGrant = NUM_PORTS-1 (port 0 wins first).
REQ-031 Reads in flight at reset SHALL be discarded; no RspValid after reset release for them.
REQ-032 ReqReady SHALL be 0 during reset regardless of ReqValid.

Structure
REQ-033 Package sme_mem_pkg SHALL hold default widths, ARB_MODE constants (ARB_RR, ARB_FIXED) and port-ID width function.
REQ-034 Grant logic (round-robin/fixed, lock, burst count) SHALL be sub-module sme_rr_arbiter; command register and response pipeline stay in top.

Verification
REQ-035 Reset release, all four ports ReqValid=1 reads, RR -> grants 0,1,2,3,0 in consecutive cycles, RspValid in same order RD_LATENCY+1 cycles later.
REQ-036 Port 2 locked burst, MAX_BURST=3, ports 1 and 3 valid -> grants 2,2,2,3,1 (forced release, then RR).
REQ-037 ARB_MODE=1, ports 1 and 3 valid continuously -> port 1 granted every cycle, port 3 never.
REQ-038 Port 0 write addr 0x3A data 0x155, then port 1 read 0x3A with model memory -> MemWriteEnable at N+1, RspValid[1] with RspData 0x155.
REQ-039 RD_LATENCY=3, 6 back-to-back reads alternating ports 0/2 -> 6 RspValid pulses, no gaps, correct port tags.
REQ-040 ResetIn_n low one cycle with 2 reads in flight -> no RspValid afterwards, next grant goes to port 0.
